// File: rtl/serdes_model_pkg.sv
// Shared types and helpers for the behavioural SerDes lane models.
// Holds the alignment FSM state encoding and the comma generator.
package serdes_model_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    CONFIRM,
    LOCKED
  } serdes_align_state_t;

  localparam int MAX_WORD = 256;

  // Comma: 8'hBC in the first-received byte, 8'h55 fill above it.
  function automatic logic [MAX_WORD-1:0] align_word(
    input int width
  );
    logic [MAX_WORD-1:0] w;
    w = '0;
    for (int i = 0; i < MAX_WORD / 8; i++) begin
      if (i < width / 8) begin
        w[i*8 +: 8] = (i == 0) ? 8'hBC : 8'h55;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/serdes_delay_line.sv
// Selectable-tap skew line on the serial bit stream.
// Tap 0 is one bitclk of delay; sel changes apply on the next bitclk.
module serdes_delay_line #(
  parameter int MAX_DELAY_CYC = 16,
  localparam int SW = $clog2(MAX_DELAY_CYC)
) (
  input  logic          bitclk,
  input  logic          rx_reset_n,
  input  logic          din,
  input  logic [SW-1:0] sel,
  output logic          dout
);

  logic [MAX_DELAY_CYC-1:0] taps;

  always_ff @(posedge bitclk or negedge rx_reset_n) begin
    if (!rx_reset_n) begin
      taps <= '0;
    end else begin
      taps <= {taps[MAX_DELAY_CYC-2:0], din};
    end
  end

  assign dout = taps[sel];

endmodule

// File: rtl/serdes_rx_align_model.sv
// Behavioural RX SerDes lane: skew delay, deserializer and
// comma-based word alignment with confirm-before-lock.
module serdes_rx_align_model
  import serdes_model_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int MAX_DELAY_CYC = 16,
  parameter logic [DATA_WIDTH-1:0] ALIGN_WORD =
    DATA_WIDTH'(align_word(DATA_WIDTH)),
  parameter int LOCK_COUNT    = 4,
  localparam int SW = $clog2(MAX_DELAY_CYC),
  localparam int CW = $clog2(DATA_WIDTH)
) (
  input  logic                  bitclk,
  input  logic                  rx_reset_n,
  input  logic                  enable,
  input  logic                  rx_align,
  input  logic [SW-1:0]         delay_sel,
  input  logic                  rxp,
  output logic                  rxclk,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_locked,
  output logic                  rx_valid,
  output logic [CW-1:0]         align_offset
);

  localparam int MW = $clog2(LOCK_COUNT + 1);

  serdes_align_state_t   state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [MW-1:0]         mcount;
  logic                  align_prev;
  logic                  serial;
  logic                  match;
  logic                  at_off;
  logic                  align_rise;

  serdes_delay_line #(
    .MAX_DELAY_CYC(MAX_DELAY_CYC)
  ) u_delay (
    .bitclk    (bitclk),
    .rx_reset_n(rx_reset_n),
    .din       (rxp),
    .sel       (delay_sel),
    .dout      (serial)
  );

  assign match      = (shreg == ALIGN_WORD);
  assign at_off     = (cnt == align_offset);
  assign align_rise = rx_align & ~align_prev;

  always_ff @(posedge bitclk or negedge rx_reset_n) begin
    if (!rx_reset_n) begin
      cnt   <= '0;
      rxclk <= 1'b0;
      shreg <= '0;
    end else begin
      rxclk <= (cnt < CW'(DATA_WIDTH / 2));
      shreg <= {serial, shreg[DATA_WIDTH-1:1]};
      if (!enable) begin
        cnt <= '0;
      end else if (cnt == CW'(DATA_WIDTH - 1)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge bitclk or negedge rx_reset_n) begin
    if (!rx_reset_n) begin
      state        <= IDLE;
      align_offset <= '0;
      mcount       <= '0;
      align_prev   <= 1'b0;
      rx_locked    <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
    end else begin
      align_prev <= rx_align;
      rx_valid   <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        mcount    <= '0;
        rx_locked <= 1'b0;
        rx_data   <= '0;
      end else begin
        unique case (state)
          IDLE: state <= SEARCH;
          SEARCH: begin
            if (match && rx_align) begin
              align_offset <= cnt;
              mcount       <= MW'(1);
              if (LOCK_COUNT == 1) begin
                state     <= LOCKED;
                rx_locked <= 1'b1;
              end else begin
                state <= CONFIRM;
              end
            end
          end
          // Only the latched phase is checked; other matches are ignored.
          CONFIRM: begin
            if (at_off) begin
              if (!match) begin
                state  <= SEARCH;
                mcount <= '0;
              end else if (mcount == MW'(LOCK_COUNT - 1)) begin
                state     <= LOCKED;
                rx_locked <= 1'b1;
                mcount    <= MW'(LOCK_COUNT);
              end else begin
                mcount <= mcount + MW'(1);
              end
            end
          end
          // A realign request beats a capture on the same cycle.
          LOCKED: begin
            if (align_rise) begin
              state     <= SEARCH;
              rx_locked <= 1'b0;
              mcount    <= '0;
            end else if (at_off) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serdes_rx_align_model.sv
// Directed bench for serdes_rx_align_model (16-bit words, 16 taps).
// Word-level table plus hand sequences for realign, disable, reset.
module tb_serdes_rx_align_model;

  localparam logic [15:0] COMMA = 16'h55BC;

  logic        bitclk = 1'b0;
  logic        rx_reset_n;
  logic        enable;
  logic        rx_align;
  logic [3:0]  delay_sel;
  logic        rxp;
  logic        rxclk;
  logic [15:0] rx_data;
  logic        rx_locked;
  logic        rx_valid;
  logic [3:0]  align_offset;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 bitclk = ~bitclk;

  serdes_rx_align_model dut (
    .bitclk      (bitclk),
    .rx_reset_n  (rx_reset_n),
    .enable      (enable),
    .rx_align    (rx_align),
    .delay_sel   (delay_sel),
    .rxp         (rxp),
    .rxclk       (rxclk),
    .rx_data     (rx_data),
    .rx_locked   (rx_locked),
    .rx_valid    (rx_valid),
    .align_offset(align_offset)
  );

  typedef struct {
    logic [15:0] word;
    logic        locked;
    int          valids;
    logic [15:0] data;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [15:0] w, input logic l,
                     input int v, input logic [15:0] d);
    vec_t r;
    r.word = w; r.locked = l; r.valids = v; r.data = d;
    tbl.push_back(r);
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge bitclk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, output int nv);
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      rxp = w[i];
      tick();
      if (rx_valid) nv++;
    end
  endtask

  task automatic do_reset(input logic [3:0] sel);
    enable     = 1'b0;
    rx_align   = 1'b0;
    rxp        = 1'b0;
    delay_sel  = sel;
    rx_reset_n = 1'b0;
    tick();
    tick();
    rx_reset_n = 1'b1;
  endtask

  task automatic run_rows(input int tag, input int first,
                          input int last);
    int nv;
    for (int r = first; r <= last; r++) begin
      send_word(tbl[r].word, nv);
      check($sformatf("t%0d row%0d locked", tag, r),
            32'(rx_locked), 32'(tbl[r].locked));
      check($sformatf("t%0d row%0d valids", tag, r),
            32'(nv), 32'(tbl[r].valids));
      check($sformatf("t%0d row%0d data", tag, r),
            32'(rx_data), 32'(tbl[r].data));
    end
  endtask

  initial begin
    int nv;
    int off0;
    int off7;

    // rows 0..6: lock on 4 commas, then capture data words
    add(COMMA,    1'b0, 0, 16'h0000);
    add(COMMA,    1'b0, 0, 16'h0000);
    add(COMMA,    1'b0, 0, 16'h0000);
    add(COMMA,    1'b0, 0, 16'h0000);
    add(16'hA5C3, 1'b1, 0, 16'h0000);
    add(16'h1357, 1'b1, 1, 16'hA5C3);
    add(16'h2468, 1'b1, 1, 16'h1357);
    // rows 7..16: corrupt word during CONFIRM forces a fresh search
    add(COMMA,    1'b0, 0, 16'h0000);
    add(COMMA,    1'b0, 0, 16'h0000);
    add(COMMA,    1'b0, 0, 16'h0000);
    add(16'h55BD, 1'b0, 0, 16'h0000);
    add(COMMA,    1'b0, 0, 16'h0000);
    add(COMMA,    1'b0, 0, 16'h0000);
    add(COMMA,    1'b0, 0, 16'h0000);
    add(COMMA,    1'b0, 0, 16'h0000);
    add(16'h0F0F, 1'b1, 0, 16'h0000);
    add(16'hBEEF, 1'b1, 1, 16'h0F0F);

    // test 1: reset state, then lock with zero skew
    do_reset(4'd0);
    check("reset rxclk", 32'(rxclk), 0);
    check("reset rx_data", 32'(rx_data), 0);
    check("reset rx_locked", 32'(rx_locked), 0);
    check("reset rx_valid", 32'(rx_valid), 0);
    check("reset align_offset", 32'(align_offset), 0);
    enable   = 1'b1;
    rx_align = 1'b1;
    run_rows(1, 0, 6);
    off0 = int'(align_offset);
    check("t1 align_offset", 32'(off0), 1);

    // test 2: same stream through seven extra taps
    do_reset(4'd7);
    enable   = 1'b1;
    rx_align = 1'b1;
    run_rows(2, 0, 6);
    off7 = int'(align_offset);
    check("t2 align_offset", 32'(off7), 8);
    check("t2 offset delta", 32'((off7 - off0 + 16) % 16), 7);

    // test 3: corrupt comma in CONFIRM
    do_reset(4'd0);
    enable   = 1'b1;
    rx_align = 1'b1;
    run_rows(3, 7, 16);
    check("t3 align_offset", 32'(align_offset), 1);

    // test 4: realign while the bit phase slips by three
    do_reset(4'd0);
    enable   = 1'b1;
    rx_align = 1'b1;
    for (int k = 0; k < 4; k++) send_word(COMMA, nv);
    send_word(16'h1111, nv);
    check("t4 locked", 32'(rx_locked), 1);
    send_word(16'h2222, nv);
    check("t4 valids", 32'(nv), 1);
    check("t4 data", 32'(rx_data), 32'h1111);
    rxp      = 1'b0;
    rx_align = 1'b0;
    tick();
    check("t4 pre-rise locked", 32'(rx_locked), 1);
    rx_align = 1'b1;
    tick();
    check("t4 unlock", 32'(rx_locked), 0);
    check("t4 no capture on rise", 32'(rx_valid), 0);
    check("t4 data hold", 32'(rx_data), 32'h1111);
    tick();
    for (int k = 0; k < 4; k++) send_word(COMMA, nv);
    check("t4 not yet relocked", 32'(rx_locked), 0);
    send_word(16'hC0DE, nv);
    check("t4 relocked", 32'(rx_locked), 1);
    check("t4 new offset", 32'(align_offset), 4);
    send_word(16'h0000, nv);
    check("t4 relock valids", 32'(nv), 1);
    check("t4 relock data", 32'(rx_data), 32'hC0DE);

    // test 5: drop enable mid-word while locked
    for (int i = 0; i < 5; i++) begin
      rxp = i[0];
      tick();
    end
    enable = 1'b0;
    tick();
    check("t5 locked", 32'(rx_locked), 0);
    check("t5 valid", 32'(rx_valid), 0);
    check("t5 data", 32'(rx_data), 0);
    tick();
    check("t5 rxclk held", 32'(rxclk), 1);

    // test 6: async reset mid-CONFIRM, then level-sensitive search
    do_reset(4'd0);
    enable   = 1'b1;
    rx_align = 1'b1;
    send_word(COMMA, nv);
    send_word(COMMA, nv);
    for (int i = 0; i < 4; i++) begin
      rxp = COMMA[i];
      tick();
    end
    check("t6 pre offset", 32'(align_offset), 1);
    check("t6 pre rxclk", 32'(rxclk), 1);
    rx_reset_n = 1'b0;
    #1;
    check("t6 async offset", 32'(align_offset), 0);
    check("t6 async rxclk", 32'(rxclk), 0);
    check("t6 async locked", 32'(rx_locked), 0);
    check("t6 async data", 32'(rx_data), 0);
    tick();
    rx_align   = 1'b0;
    rxp        = 1'b0;
    rx_reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      send_word(COMMA, nv);
      check($sformatf("t6 no-align word%0d locked", k),
            32'(rx_locked), 0);
      check($sformatf("t6 no-align word%0d offset", k),
            32'(align_offset), 0);
    end
    rx_align = 1'b1;
    for (int k = 6; k < 10; k++) begin
      send_word(COMMA, nv);
      if (k == 8) check("t6 early lock", 32'(rx_locked), 0);
      if (k == 9) check("t6 lock", 32'(rx_locked), 1);
    end
    check("t6 offset", 32'(align_offset), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
